// File: rtl/timer_counter.sv
// Timer count register with compare and overflow flags.
// Software-writable count/compare halves, sticky status, level interrupt.
module timer_counter #(
    parameter int                  DATA_W  = 32,
    parameter logic [2*DATA_W-1:0] CMP_RST = {2*DATA_W{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    input  logic                  cnt_lo_we,
    input  logic                  cnt_hi_we,
    input  logic                  cmp_lo_we,
    input  logic                  cmp_hi_we,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  int_en,
    input  logic                  int_clr,
    input  logic                  ovf_clr,
    output logic [2*DATA_W-1:0]   cnt,
    output logic [2*DATA_W-1:0]   cmp,
    output logic                  int_st,
    output logic                  ovf_st,
    output logic                  tim_int
);

    localparam int CNT_W = 2 * DATA_W;
    localparam int NB    = DATA_W / 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             int_st_q, int_st_d;
    logic             ovf_st_q, ovf_st_d;
    logic             match;
    logic             wrap;

    // Byte-lane merge of write data into one register half.
    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] wd,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                r[b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // Next count: clear beats software write beats increment.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_lo_we || cnt_hi_we) begin
            if (cnt_lo_we) begin
                cnt_d[DATA_W-1:0] = merge(cnt_q[DATA_W-1:0], wdata, wstrb);
            end
            if (cnt_hi_we) begin
                cnt_d[CNT_W-1:DATA_W] = merge(cnt_q[CNT_W-1:DATA_W], wdata, wstrb);
            end
        end else if (cnt_en) begin
            cnt_d = cnt_q + CNT_W'(1);
            wrap  = &cnt_q;
        end
    end

    // Next compare value: only software writes touch it.
    always_comb begin
        cmp_d = cmp_q;
        if (cmp_lo_we) begin
            cmp_d[DATA_W-1:0] = merge(cmp_q[DATA_W-1:0], wdata, wstrb);
        end
        if (cmp_hi_we) begin
            cmp_d[CNT_W-1:DATA_W] = merge(cmp_q[CNT_W-1:DATA_W], wdata, wstrb);
        end
    end

    // Sticky status: a same-cycle set wins over the clear strobe.
    always_comb begin
        match    = (cnt_q == cmp_q);
        int_st_d = int_st_q;
        ovf_st_d = ovf_st_q;
        if (match) begin
            int_st_d = 1'b1;
        end else if (int_clr) begin
            int_st_d = 1'b0;
        end
        if (wrap) begin
            ovf_st_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_st_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            cmp_q    <= CMP_RST;
            int_st_q <= 1'b0;
            ovf_st_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            int_st_q <= int_st_d;
            ovf_st_q <= ovf_st_d;
        end
    end

    assign cnt     = cnt_q;
    assign cmp     = cmp_q;
    assign int_st  = int_st_q;
    assign ovf_st  = ovf_st_q;
    assign tim_int = int_st_q & int_en;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: cycle model plus directed vectors.
// Model is checked every negedge; literals pin key points.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cnt_en = 0, cnt_clr = 0;
    logic        cnt_lo_we = 0, cnt_hi_we = 0;
    logic        cmp_lo_we = 0, cmp_hi_we = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        int_en = 0, int_clr = 0, ovf_clr = 0;
    logic [63:0] cnt, cmp;
    logic        int_st, ovf_st, tim_int;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_cnt, m_cmp;
    logic        m_int, m_ovf;
    bit          m_valid = 0;

    timer_counter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .cnt_lo_we(cnt_lo_we), .cnt_hi_we(cnt_hi_we),
        .cmp_lo_we(cmp_lo_we), .cmp_hi_we(cmp_hi_we),
        .wdata(wdata), .wstrb(wstrb), .int_en(int_en),
        .int_clr(int_clr), .ovf_clr(ovf_clr),
        .cnt(cnt), .cmp(cmp), .int_st(int_st),
        .ovf_st(ovf_st), .tim_int(tim_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Bit mask covering the enabled bytes of the selected halves.
    function automatic logic [63:0] wmask(input logic lo, input logic hi,
                                          input logic [3:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (((i < 4) ? lo : hi) && be[i % 4]) m |= 64'hFF << (8 * i);
        end
        return m;
    endfunction

    // Reference model, one step per rising edge.
    always @(posedge clk) begin
        logic [63:0] nc, nm;
        logic        ni, no, wr;
        if (rst) begin
            m_cnt = '0; m_cmp = '1; m_int = 0; m_ovf = 0;
        end else begin
            ni = (m_cnt == m_cmp) ? 1'b1 : (int_clr ? 1'b0 : m_int);
            wr = 0;
            nc = m_cnt;
            if (cnt_clr) nc = 0;
            else if (cnt_lo_we || cnt_hi_we) begin
                nm = wmask(cnt_lo_we, cnt_hi_we, wstrb);
                nc = (m_cnt & ~nm) | ({wdata, wdata} & nm);
            end else if (cnt_en) begin
                nc = m_cnt + 1;
                wr = (nc == 0);
            end
            nm = wmask(cmp_lo_we, cmp_hi_we, wstrb);
            m_cmp = (m_cmp & ~nm) | ({wdata, wdata} & nm);
            no = wr ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            m_cnt = nc; m_int = ni; m_ovf = no;
        end
        m_valid = 1;
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cnt", cnt, m_cnt);
            chk("cmp", cmp, m_cmp);
            chk("int_st", 64'(int_st), 64'(m_int));
            chk("ovf_st", 64'(ovf_st), 64'(m_ovf));
            chk("tim_int", 64'(tim_int), 64'(m_int & int_en));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cnt_en = 0; cnt_clr = 0; cnt_lo_we = 0; cnt_hi_we = 0;
        cmp_lo_we = 0; cmp_hi_we = 0; int_clr = 0; ovf_clr = 0;
        wstrb = 4'hF;
    endtask

    initial begin
        idle();
        repeat (2) cyc();
        rst = 0;
        chk("rst_cnt", cnt, 64'h0);
        chk("rst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_int", 64'(int_st), 64'h0);

        // 1: five ticks then clear
        cnt_en = 1;
        repeat (5) cyc();
        cnt_en = 0;
        chk("t1_cnt5", cnt, 64'd5);
        cnt_clr = 1; cyc(); cnt_clr = 0;
        chk("t1_clr", cnt, 64'd0);
        chk("t1_ovf", 64'(ovf_st), 64'h0);

        // 2: compare at 10
        cmp_hi_we = 1; wdata = 32'h0; cyc(); idle();
        cmp_lo_we = 1; wdata = 32'd10; cyc(); idle();
        chk("t2_cmp", cmp, 64'd10);
        cnt_en = 1;
        repeat (10) cyc();
        chk("t2_cnt10", cnt, 64'd10);
        chk("t2_int0", 64'(int_st), 64'h0);
        cyc();
        chk("t2_int1", 64'(int_st), 64'h1);
        int_en = 1; #1;
        chk("t2_timint", 64'(tim_int), 64'h1);
        cyc();
        chk("t2_cnt12", cnt, 64'd12);
        int_clr = 1; cyc(); idle();
        chk("t2_intclr", 64'(int_st), 64'h0);
        int_en = 0;

        // 3: full wrap and overflow stickiness
        cnt_lo_we = 1; cnt_hi_we = 1; wdata = 32'hFFFF_FFFF; cyc(); idle();
        chk("t3_ones", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        cnt_en = 1; cyc(); idle();
        chk("t3_wrap", cnt, 64'h0);
        chk("t3_ovf", 64'(ovf_st), 64'h1);
        cnt_lo_we = 1; cnt_hi_we = 1; wdata = 32'hFFFF_FFFF; cyc(); idle();
        cnt_en = 1; ovf_clr = 1; cyc(); idle();
        chk("t3_setwins", 64'(ovf_st), 64'h1);
        ovf_clr = 1; cyc(); idle();
        chk("t3_ovfclr", 64'(ovf_st), 64'h0);

        // 4: carry across halves
        cnt_hi_we = 1; wdata = 32'h0; cyc(); idle();
        cnt_lo_we = 1; wdata = 32'hFFFF_FFFF; cyc(); idle();
        cnt_en = 1; cyc(); idle();
        chk("t4_carry", cnt, 64'h0000_0001_0000_0000);

        // 5: byte write blocks increment; clear beats write
        cnt_lo_we = 1; wdata = 32'h1234_5678; cyc(); idle();
        cnt_lo_we = 1; wstrb = 4'b0010; wdata = 32'h0000_AB00; cnt_en = 1;
        cyc(); idle();
        chk("t5_byte", cnt, 64'h0000_0001_1234_AB78);
        cnt_clr = 1; cnt_lo_we = 1; wdata = 32'hFFFF_FFFF; cyc(); idle();
        chk("t5_clrwr", cnt, 64'h0);

        // 6: level match holds int_st; reset mid-count
        cmp_lo_we = 1; wdata = 32'd3; cyc(); idle();
        cnt_en = 1; repeat (3) cyc(); idle();
        chk("t6_cnt3", cnt, 64'd3);
        cyc();
        chk("t6_int1", 64'(int_st), 64'h1);
        int_clr = 1; cyc(); idle();
        chk("t6_hold", 64'(int_st), 64'h1);
        int_en = 1;
        cnt_en = 1; repeat (2) cyc();
        chk("t6_cnt5", cnt, 64'd5);
        rst = 1; cmp_lo_we = 1; wdata = 32'd7; cyc(); idle();
        chk("t6_rcnt", cnt, 64'h0);
        chk("t6_rcmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_rint", 64'(int_st), 64'h0);
        chk("t6_rovf", 64'(ovf_st), 64'h0);
        chk("t6_rtim", 64'(tim_int), 64'h0);
        rst = 0; int_en = 0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
